// File: rtl/shader_pkg.sv
// Shared definitions for the pipelined test-pattern shader: pattern modes,
// pipeline latency and the colour clamp helper.
package shader_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_DISC  = 2'd3
  } mode_e;

  localparam int SHADER_LAT = 3;

  // Saturate a signed value into [0, max_val].
  function automatic logic signed [31:0] clamp(input logic signed [31:0] val,
                                               input logic signed [31:0] max_val);
    logic signed [31:0] res;
    if (val < 32'sd0) begin
      res = 32'sd0;
    end else if (val > max_val) begin
      res = max_val;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/shader_pattern.sv
// Combinational stage-3 pattern evaluation: turns decimated coordinates,
// precomputed disc squares, bar index and frame into clamped RGB.
module shader_pattern
  import shader_pkg::*;
#(
  parameter int COORD_W   = 12,
  parameter int COLOR_W   = 8,
  parameter int FRAME_W   = 8,
  parameter int CHECK_BIT = 2,
  parameter int RADIUS2   = 400
) (
  input  mode_e                mode_i,
  input  logic [COORD_W-1:0]   x_i,
  input  logic [COORD_W-1:0]   y_i,
  input  logic signed [31:0]   u2_i,
  input  logic signed [31:0]   v2_i,
  input  logic [2:0]           bar_i,
  input  logic [FRAME_W-1:0]   frame_i,
  output logic [COLOR_W-1:0]   red_o,
  output logic [COLOR_W-1:0]   green_o,
  output logic [COLOR_W-1:0]   blue_o
);

  localparam logic signed [31:0] MAX_S = (32'sd1 <<< COLOR_W) - 32'sd1;
  localparam logic [COLOR_W-1:0] MAX_C = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] ZERO_C = {COLOR_W{1'b0}};

  logic signed [31:0]   x_s;
  logic signed [31:0]   y_s;
  logic signed [31:0]   h_s;
  logic [COLOR_W-1:0]   xf_s;
  logic [COLOR_W-1:0]   disc_red_s;
  logic                 chk_s;

  assign x_s        = $signed(32'(x_i));
  assign y_s        = $signed(32'(y_i));
  assign h_s        = u2_i + v2_i;
  // Animated x coordinate, already reduced modulo the channel range.
  assign xf_s       = COLOR_W'(x_s + $signed(32'(frame_i)));
  assign chk_s      = xf_s[CHECK_BIT] ^ y_i[CHECK_BIT];
  assign disc_red_s = COLOR_W'(clamp(MAX_S - (h_s >>> 1), MAX_S));

  // Pattern select and per-channel colour generation.
  always_comb begin
    red_o   = ZERO_C;
    green_o = ZERO_C;
    blue_o  = ZERO_C;
    case (mode_i)
      MODE_BARS: begin
        red_o   = bar_i[0] ? MAX_C : ZERO_C;
        green_o = bar_i[1] ? MAX_C : ZERO_C;
        blue_o  = bar_i[2] ? MAX_C : ZERO_C;
      end
      MODE_GRAD: begin
        red_o   = xf_s;
        green_o = COLOR_W'(y_i);
        blue_o  = COLOR_W'(x_s + y_s);
      end
      MODE_CHECK: begin
        red_o   = chk_s ? MAX_C : ZERO_C;
        green_o = chk_s ? MAX_C : ZERO_C;
        blue_o  = chk_s ? MAX_C : ZERO_C;
      end
      MODE_DISC: begin
        if (h_s < RADIUS2) begin
          red_o   = disc_red_s;
          green_o = disc_red_s >> 1;
          blue_o  = ZERO_C;
        end else begin
          red_o   = ZERO_C;
          green_o = ZERO_C;
          blue_o  = COLOR_W'(clamp(y_s * 32'sd4, MAX_S));
        end
      end
      default: begin
        red_o   = ZERO_C;
        green_o = ZERO_C;
        blue_o  = ZERO_C;
      end
    endcase
  end

endmodule

// File: rtl/shader_pipe.sv
// Three-stage registered test-pattern shader between the timing generator and
// the video encoder; mode and frame counter update only on frame_start.
module shader_pipe
  import shader_pkg::*;
#(
  parameter int COORD_W   = 12,
  parameter int COLOR_W   = 8,
  parameter int SHIFT     = 3,
  parameter int CX        = 40,
  parameter int CY        = 30,
  parameter int RADIUS2   = 400,
  parameter int BAR_SHIFT = 7,
  parameter int CHECK_BIT = 2,
  parameter int FRAME_W   = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                in_valid,
  input  logic [COORD_W-1:0]  hcount,
  input  logic [COORD_W-1:0]  vcount,
  input  logic                frame_start,
  input  logic [1:0]          mode_sel,
  output logic                out_valid,
  output logic [COLOR_W-1:0]  red,
  output logic [COLOR_W-1:0]  green,
  output logic [COLOR_W-1:0]  blue,
  output logic [FRAME_W-1:0]  frame_count
);

  localparam logic [COLOR_W-1:0] ZERO_C = {COLOR_W{1'b0}};

  mode_e                   mode_q, mode_d;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic [SHADER_LAT-1:0]   vld_q, vld_d;

  logic [COORD_W-1:0]      x1_q, x1_d, y1_q, y1_d;
  logic [2:0]              bar1_q, bar1_d;
  mode_e                   mode1_q, mode1_d;
  logic [FRAME_W-1:0]      frame1_q, frame1_d;

  logic signed [31:0]      u_s, v_s;
  logic signed [31:0]      u2_q, u2_d, v2_q, v2_d;
  logic [COORD_W-1:0]      x2_q, x2_d, y2_q, y2_d;
  logic [2:0]              bar2_q, bar2_d;
  mode_e                   mode2_q, mode2_d;
  logic [FRAME_W-1:0]      frame2_q, frame2_d;

  logic [COLOR_W-1:0]      pat_red_s, pat_green_s, pat_blue_s;
  logic [COLOR_W-1:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;

  // Frame control: latch the requested mode and advance the frame counter.
  always_comb begin
    mode_d  = mode_q;
    frame_d = frame_q;
    if (frame_start) begin
      mode_d  = mode_e'(mode_sel);
      frame_d = frame_q + FRAME_W'(1'b1);
    end else begin
      mode_d  = mode_q;
      frame_d = frame_q;
    end
  end

  // Datapath next-state for all three stages; stage 1 sees the pre-update mode.
  always_comb begin
    vld_d    = {vld_q[SHADER_LAT-2:0], in_valid};

    x1_d     = hcount >> SHIFT;
    y1_d     = vcount >> SHIFT;
    bar1_d   = 3'(hcount >> BAR_SHIFT);
    mode1_d  = mode_q;
    frame1_d = frame_q;

    u_s      = $signed(32'(x1_q)) - CX;
    v_s      = CY - $signed(32'(y1_q));
    u2_d     = u_s * u_s;
    v2_d     = v_s * v_s;
    x2_d     = x1_q;
    y2_d     = y1_q;
    bar2_d   = bar1_q;
    mode2_d  = mode1_q;
    frame2_d = frame1_q;

    red_d    = ZERO_C;
    green_d  = ZERO_C;
    blue_d   = ZERO_C;
    if (vld_q[1]) begin
      red_d   = pat_red_s;
      green_d = pat_green_s;
      blue_d  = pat_blue_s;
    end else begin
      red_d   = ZERO_C;
      green_d = ZERO_C;
      blue_d  = ZERO_C;
    end
  end

  shader_pattern #(
    .COORD_W   (COORD_W),
    .COLOR_W   (COLOR_W),
    .FRAME_W   (FRAME_W),
    .CHECK_BIT (CHECK_BIT),
    .RADIUS2   (RADIUS2)
  ) u_pattern (
    .mode_i  (mode2_q),
    .x_i     (x2_q),
    .y_i     (y2_q),
    .u2_i    (u2_q),
    .v2_i    (v2_q),
    .bar_i   (bar2_q),
    .frame_i (frame2_q),
    .red_o   (pat_red_s),
    .green_o (pat_green_s),
    .blue_o  (pat_blue_s)
  );

  // State and pipeline registers; reset flushes everything in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q   <= MODE_BARS;
      frame_q  <= {FRAME_W{1'b0}};
      vld_q    <= {SHADER_LAT{1'b0}};
      x1_q     <= {COORD_W{1'b0}};
      y1_q     <= {COORD_W{1'b0}};
      bar1_q   <= 3'd0;
      mode1_q  <= MODE_BARS;
      frame1_q <= {FRAME_W{1'b0}};
      u2_q     <= 32'sd0;
      v2_q     <= 32'sd0;
      x2_q     <= {COORD_W{1'b0}};
      y2_q     <= {COORD_W{1'b0}};
      bar2_q   <= 3'd0;
      mode2_q  <= MODE_BARS;
      frame2_q <= {FRAME_W{1'b0}};
      red_q    <= ZERO_C;
      green_q  <= ZERO_C;
      blue_q   <= ZERO_C;
    end else begin
      mode_q   <= mode_d;
      frame_q  <= frame_d;
      vld_q    <= vld_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      bar1_q   <= bar1_d;
      mode1_q  <= mode1_d;
      frame1_q <= frame1_d;
      u2_q     <= u2_d;
      v2_q     <= v2_d;
      x2_q     <= x2_d;
      y2_q     <= y2_d;
      bar2_q   <= bar2_d;
      mode2_q  <= mode2_d;
      frame2_q <= frame2_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign out_valid   = vld_q[SHADER_LAT-1];
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_shader_pipe.sv
// Scoreboard bench for shader_pipe: a driver pushes expected pixels from a
// plain-arithmetic reference model; a monitor pops and compares every cycle.
module tb_shader_pipe;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        frame_start;
  logic [1:0]  mode_sel;
  logic        out_valid;
  logic [7:0]  red, green, blue;
  logic [7:0]  frame_count;

  typedef struct {
    int due;
    int r;
    int g;
    int b;
  } exp_t;

  exp_t exp_q[$];
  int   m_mode  = 0;
  int   m_frame = 0;
  int   drv_cyc = 0;
  int   ec      = 0;
  int   n_vec   = 0;
  int   n_fail  = 0;

  shader_pipe dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .in_valid    (in_valid),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .mode_sel    (mode_sel),
    .out_valid   (out_valid),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_count (frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int clampi(input int val);
    if (val < 0) return 0;
    if (val > 255) return 255;
    return val;
  endfunction

  // Reference: pattern computed straight from the pixel coordinates.
  task automatic model_pixel(input int mode, input int frame, input int h, input int v,
                             output int r, output int g, output int b);
    int x, y, bar, c, dist2;
    x = h / 8;
    y = v / 8;
    bar = (h / 128) % 8;
    r = 0; g = 0; b = 0;
    case (mode)
      0: begin
        r = (bar % 2) ? 255 : 0;
        g = ((bar / 2) % 2) ? 255 : 0;
        b = ((bar / 4) % 2) ? 255 : 0;
      end
      1: begin
        r = (x + frame) % 256;
        g = y % 256;
        b = (x + y) % 256;
      end
      2: begin
        c = (((x + frame) / 4) % 2) ^ ((y / 4) % 2);
        r = c ? 255 : 0; g = r; b = r;
      end
      default: begin
        dist2 = (x - 40) * (x - 40) + (30 - y) * (30 - y);
        if (dist2 < 400) begin
          r = clampi(255 - dist2 / 2);
          g = r / 2;
          b = 0;
        end else begin
          b = clampi(4 * y);
        end
      end
    endcase
  endtask

  task automatic step(input bit rst, input bit vld, input int h, input int v,
                      input bit fs, input int ms);
    exp_t e;
    @(negedge sys_clk);
    drv_cyc++;
    sys_rst     = rst;
    in_valid    = vld;
    hcount      = vld ? h[11:0] : 12'($urandom);
    vcount      = vld ? v[11:0] : 12'($urandom);
    frame_start = fs;
    mode_sel    = ms[1:0];
    if (rst) begin
      exp_q.delete();
      m_mode  = 0;
      m_frame = 0;
    end else begin
      if (vld) begin
        model_pixel(m_mode, m_frame, h, v, e.r, e.g, e.b);
        e.due = drv_cyc + 2;
        exp_q.push_back(e);
      end
      if (fs) begin
        m_mode  = ms;
        m_frame = (m_frame + 1) % 256;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  // Monitor: compare outputs against the scoreboard after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].due < ec) begin
        e = exp_q.pop_front();
        n_vec++; n_fail++;
        $display("FAIL missed_pixel: due edge %0d never produced (now edge %0d)", e.due, ec);
      end
      n_vec++;
      if (exp_q.size() > 0 && exp_q[0].due == ec) begin
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || red !== e.r[7:0] || green !== e.g[7:0] || blue !== e.b[7:0]) begin
          n_fail++;
          $display("FAIL pixel: edge %0d got v=%0b rgb=(%0d,%0d,%0d) want v=1 rgb=(%0d,%0d,%0d)",
                   ec, out_valid, red, green, blue, e.r, e.g, e.b);
        end
      end else begin
        if (out_valid !== 1'b0 || red !== 8'd0 || green !== 8'd0 || blue !== 8'd0) begin
          n_fail++;
          $display("FAIL blank: edge %0d got v=%0b rgb=(%0d,%0d,%0d) want v=0 rgb=(0,0,0)",
                   ec, out_valid, red, green, blue);
        end
      end
      n_vec++;
      if (frame_count !== m_frame[7:0]) begin
        n_fail++;
        $display("FAIL frame_count: edge %0d got %0d want %0d", ec, frame_count, m_frame);
      end
      ec++;
    end
  end

  // Driver: directed cases from the plan, then randomized traffic.
  initial begin
    sys_rst = 1'b1; in_valid = 1'b0; hcount = 12'd0; vcount = 12'd0;
    frame_start = 1'b0; mode_sel = 2'd0;
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 384, 0, 1'b0, 0);
    idle(5);
    step(1'b0, 1'b1, 384, 0, 1'b0, 0);
    step(1'b0, 1'b1, 896, 0, 1'b0, 0);
    idle(3);
    step(1'b0, 1'b0, 0, 0, 1'b1, 3);
    step(1'b0, 1'b1, 320, 240, 1'b0, 0);
    step(1'b0, 1'b1, 0, 80, 1'b0, 0);
    idle(3);
    step(1'b0, 1'b0, 0, 0, 1'b1, 2);
    step(1'b0, 1'b1, 0, 0, 1'b0, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b1, 2);
    step(1'b0, 1'b1, 0, 0, 1'b0, 2);
    idle(3);
    step(1'b0, 1'b0, 0, 0, 1'b1, 0);
    step(1'b0, 1'b1, 384, 8, 1'b0, 1);
    step(1'b0, 1'b1, 384, 8, 1'b0, 1);
    step(1'b0, 1'b1, 384, 8, 1'b1, 1);
    step(1'b0, 1'b1, 384, 8, 1'b0, 1);
    idle(3);
    for (int i = 0; i < 258; i++) step(1'b0, 1'b0, 0, 0, 1'b1, 0);
    step(1'b0, 1'b1, 384, 0, 1'b0, 0);
    step(1'b0, 1'b1, 896, 0, 1'b0, 0);
    step(1'b1, 1'b1, 320, 240, 1'b0, 0);
    idle(5);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)));
    end
    idle(6);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pixels still pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/shader_pipe.md
Name: shader_pipe

Overview:
Pipelined, parametrised successor to the combinational test-pattern shader. Takes the video timing generator's pixel coordinates and produces RGB through a registered 3-stage pipeline with a valid strobe. Adds four selectable patterns, with mode changes applied only at frame boundaries, and a frame counter that animates the gradient and checker patterns. Sits between the timing generator and the DVI/HDMI encoder.

Parameters:
COORD_W, 12, width of hcount/vcount
COLOR_W, 8, width of each colour channel; channel max MAX = 2^COLOR_W-1
SHIFT, 3, coordinate decimation: x = hcount>>SHIFT, y = vcount>>SHIFT
CX, 40, disc centre x in decimated units
CY, 30, disc centre y in decimated units
RADIUS2, 400, squared disc radius in decimated units
BAR_SHIFT, 7, colour-bar width is 2^BAR_SHIFT pixels
CHECK_BIT, 2, checker cell size is 2^CHECK_BIT decimated units
FRAME_W, 8, frame counter width

Ports:
sys_clk  in  1  clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
in_valid  in  1  pixel in active video this cycle
hcount  in  COORD_W  pixel x, unsigned
vcount  in  COORD_W  pixel y, unsigned
frame_start  in  1  one-cycle pulse, issued during blanking
mode_sel  in  2  requested pattern, sampled only on frame_start
out_valid  out  1  in_valid delayed 3 cycles
red  out  COLOR_W  red channel
green  out  COLOR_W  green channel
blue  out  COLOR_W  blue channel
frame_count  out  FRAME_W  frames seen since reset

Behaviour:
- Reset (sys_rst high at a clock edge):
  - Clears all stage valids, mode_r, frame_count, red, green and blue to 0.
  - In-flight pixels are discarded.
  - The first out_valid after reset is 3 cycles after the first in_valid sampled with sys_rst low.
- Frame control on frame_start:
  - mode_r <= mode_sel.
  - frame_count <= frame_count+1, wrapping modulo 2^FRAME_W.
  - A pixel sampled in the same cycle uses the old mode_r and frame_count.
- Stage 1 registers valid, x, y, bar = (hcount>>BAR_SHIFT)&7, the mode, and the frame value.
- Stage 2 computes signed u = x-CX and v = CY-y, then registers u*u, v*v, x, y and the mode/frame.
  - Internal arithmetic is signed 32-bit; no overflow is possible at the defaults.
- Stage 3 sets h = u2+v2, evaluates the pattern, clamps, and registers the outputs.
- Clamp rule: a value below 0 becomes 0; a value above MAX becomes MAX; otherwise the low COLOR_W bits are taken.
- Patterns (mode encoding):
  - 0 BARS: red = bar[0]?MAX:0; green = bar[1]?MAX:0; blue = bar[2]?MAX:0.
  - 1 GRAD: red = (x+frame) mod 2^COLOR_W; green = y mod 2^COLOR_W; blue = (x+y) mod 2^COLOR_W.
  - 2 CHECK: c = bit CHECK_BIT of (x+frame) XOR bit CHECK_BIT of y. All channels are MAX if c=1, else 0.
  - 3 DISC:
    - If h < RADIUS2: red = clamp(MAX-(h>>1)), green = red>>1, blue = 0.
    - Otherwise: red = green = 0, blue = clamp(4*y).
- Output timing:
  - out_valid at cycle N+3 equals in_valid at cycle N. The pipeline always advances; there is no backpressure.
  - When out_valid=0, red, green and blue are forced to 0 (blanking black).
- The inputs hcount/vcount are don't-care when in_valid=0, and must not affect the outputs.

Decomposition:
- shader_pkg holds:
  - mode constants MODE_BARS=0, MODE_GRAD=1, MODE_CHECK=2, MODE_DISC=3
  - the pipeline latency constant SHADER_LAT=3
  - the clamp function
- One sub-module, shader_pattern: combinational stage-3 pattern/clamp logic. Its inputs are mode, x, y, u2, v2, bar and frame; its outputs are the unclamped-then-clamped RGB. shader_pipe owns all registers.

Test Plan:
- sys_rst for 2 cycles, then in_valid=1 for one cycle at cycle 0 -> out_valid=1 only at cycle 3; RGB=0 at all other cycles.
- Mode 0, hcount=384, vcount=0 -> bar=3 -> RGB=(255,255,0). hcount=896 -> bar=7 -> RGB=(255,255,255).
- Mode 3, hcount=320, vcount=240 -> h=0 -> RGB=(255,127,0). hcount=0, vcount=80 -> h=2000 -> RGB=(0,0,40).
- Mode 2, frame_count=0, hcount=0, vcount=0 -> RGB=(0,0,0). After 4 frame_start pulses -> (255,255,255).
- mode_sel=1 held without frame_start -> pattern stays mode 0. frame_start asserted with in_valid in the same cycle -> that pixel uses the old mode, and the next pixel uses mode 1.
- 256 frame_start pulses -> frame_count wraps 255->0. sys_rst mid-stream with 3 pixels in flight -> none appear on the outputs.
